// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_param
//  Purpose  : Single-clock parametrised FIFO with fill level, programmable
//             almost-full / almost-empty flags, sticky overflow / underflow
//             errors, synchronous flush and selectable read mode
//             (registered read or first-word-fall-through).
//  Ports    : clk          - clock, all logic on the rising edge
//             reset        - synchronous active-high reset
//             flush        - synchronous empty, overrides write/read
//             write/wdata  - write request and data
//             read         - read request (FWFT: pop the head word)
//             rdata        - read data
//             wfull/rempty - full / empty flags (registered)
//             almost_full  - level >= AF_THRESH
//             almost_empty - level <= AE_THRESH
//             level        - stored word count 0..DEPTH
//             overflow     - sticky, write attempted while full
//             underflow    - sticky, read attempted while empty
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_param #(
  parameter int WIDTH     = 32,
  parameter int ADDR      = 5,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             write,
  input  logic [WIDTH-1:0] wdata,
  input  logic             read,
  output logic [WIDTH-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    level,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ADDR:0] C_DEPTH_LVL = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] C_AF_LVL    = (ADDR+1)'(AF_THRESH);
  localparam logic [ADDR:0] C_AE_LVL    = (ADDR+1)'(AE_THRESH);

  if (DEPTH != (1 << ADDR)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must equal 2**ADDR");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR:0]    wptr_q, rptr_q;
  logic [ADDR:0]    level_q, level_d;
  logic             wfull_q, rempty_q, afull_q, aempty_q;
  logic             ovf_q, unf_q;
  logic             wr_ok, rd_ok;

  // Acceptance is judged against the flags registered at the start of the
  // cycle; flush suppresses both transfers.
  assign wr_ok = write & ~wfull_q  & ~flush;
  assign rd_ok = read  & ~rempty_q & ~flush;

  always_comb begin
    level_d = level_q + (ADDR+1)'(wr_ok) - (ADDR+1)'(rd_ok);
    if (flush) begin
      level_d = '0;
    end
  end

  // Pointers, level, flags and sticky errors. Flags come from level_d so
  // they describe the state after this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr_ok) wptr_q <= wptr_q + 1'b1;
        if (rd_ok) rptr_q <= rptr_q + 1'b1;
        // Flush masks the request, so it cannot raise an error either.
        ovf_q <= ovf_q | (write & wfull_q);
        unf_q <= unf_q | (read & rempty_q);
      end
      level_q  <= level_d;
      wfull_q  <= (level_d == C_DEPTH_LVL);
      rempty_q <= (level_d == '0);
      afull_q  <= (level_d >= C_AF_LVL);
      aempty_q <= (level_d <= C_AE_LVL);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) begin
      mem_q[wptr_q[ADDR-1:0]] <= wdata;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented combinationally; a pop exposes the next word
    // right after the same edge.
    assign rdata = mem_q[rptr_q[ADDR-1:0]];
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_q <= '0;
      end else if (rd_ok) begin
        rdata_q <= mem_q[rptr_q[ADDR-1:0]];
      end
    end
    assign rdata = rdata_q;
  end

  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
`default_nettype wire
